fetch_redirect_unit: RTL and testbench

Fetch-side consumer of the branch controller's redirect interface. It owns the architectural fetch PC and issues one 16-bit Thumb halfword fetch at a time over a req/ack instruction-memory port. It presents fetched instructions to decode with a valid bit. It applies take-branch/flush redirects from execute, including squashing any fetch already in flight when the redirect arrives.

---
 rtl/fetch_redirect_unit_pkg.sv | 28 ++
 rtl/fetch_redirect_unit_skid.sv | 50 +++++
 rtl/fetch_redirect_unit.sv | 206 ++++++++++++++++++++
 tb/tb_fetch_redirect_unit.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_redirect_unit_pkg.sv
// Shared definitions for the fetch redirect unit.
//   WORD            : architectural address width
//   PC_INCREMENT    : byte step between consecutive Thumb halfwords
//   THUMB_BIT_MASK  : clears the interworking bit of a branch target
//   fetch_state_t   : IDLE / FETCH / DRAIN
//   take_branch_ctrl_sig_t, flush_pipeline_sig_t : branch controller signal types
//   sat_inc         : saturating 32-bit increment used by the optional counters
package fetch_redirect_unit_pkg;

    localparam int WORD = 32;

    localparam logic [WORD-1:0] PC_INCREMENT   = 32'd2;
    localparam logic [WORD-1:0] THUMB_BIT_MASK = 32'hFFFF_FFFE;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    typedef logic take_branch_ctrl_sig_t;
    typedef logic flush_pipeline_sig_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/fetch_redirect_unit_skid.sv
// One-entry holding register for a halfword that came back from memory while
// decode was stalled.
//   clk_i, reset_i  : clock, async active-high reset
//   load_i          : capture inst_i/pc_i and mark valid
//   drain_i         : entry has been moved to the decode outputs
//   clear_i         : discard entry (redirect / flush), wins over load
//   inst_i, pc_i    : incoming halfword and its address
//   valid_o, inst_o, pc_o : held entry
module fetch_skid_buffer
    import fetch_redirect_unit_pkg::*;
#(
    parameter int INST_W = 16
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              load_i,
    input  logic              drain_i,
    input  logic              clear_i,
    input  logic [INST_W-1:0] inst_i,
    input  logic [WORD-1:0]   pc_i,
    output logic              valid_o,
    output logic [INST_W-1:0] inst_o,
    output logic [WORD-1:0]   pc_o
);

    logic              valid_q;
    logic [INST_W-1:0] inst_q;
    logic [WORD-1:0]   pc_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            valid_q <= 1'b0;
            inst_q  <= '0;
            pc_q    <= '0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            inst_q  <= inst_i;
            pc_q    <= pc_i;
        end else if (drain_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign inst_o  = inst_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_redirect_unit.sv
// Fetch-side consumer of the branch controller redirect interface. Owns the
// fetch PC, issues one halfword request at a time on a req/ack port and hands
// fetched instructions to decode.
//   clk_i, reset_i           : clock, async active-high reset
//   take_branch_i            : redirect to branch_target_i (bit0 dropped)
//   flush_pipeline_i         : kill decode-bound instruction, PC unchanged
//   branch_target_i          : redirect target
//   stall_i                  : decode cannot accept a new instruction
//   imem_req_o/addr_o        : request, held with its address until ack
//   imem_ack_i/rdata_i       : ack with data in the same cycle
//   instruction_o, program_counter_o, is_valid_o : decode interface
// Optional build macro FETCH_REDIRECT_STATS_EN adds redirect_count_o and
// drained_count_o (saturating event counters).
module fetch_redirect_unit
    import fetch_redirect_unit_pkg::*;
#(
    parameter logic [WORD-1:0] RESET_PC = 32'h0000_0000,
    parameter int              INST_W   = 16
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  take_branch_ctrl_sig_t take_branch_i,
    input  flush_pipeline_sig_t   flush_pipeline_i,
    input  logic [WORD-1:0]       branch_target_i,
    input  logic                  stall_i,
    output logic                  imem_req_o,
    output logic [WORD-1:0]       imem_addr_o,
    input  logic                  imem_ack_i,
    input  logic [INST_W-1:0]     imem_rdata_i,
    output logic [INST_W-1:0]     instruction_o,
    output logic [WORD-1:0]       program_counter_o,
    output logic                  is_valid_o
`ifdef FETCH_REDIRECT_STATS_EN
    ,
    output logic [31:0]           redirect_count_o,
    output logic [31:0]           drained_count_o
`endif
);

    fetch_state_t      state_q, state_d;
    logic [WORD-1:0]   pc_q, pc_d;
    logic [WORD-1:0]   req_addr_q, req_addr_d;
    logic              req_q, req_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic [WORD-1:0]   out_pc_q, out_pc_d;
    logic              valid_q, valid_d;

    logic              skid_load, skid_drain, skid_clear;
    logic              skid_valid;
    logic [INST_W-1:0] skid_inst;
    logic [WORD-1:0]   skid_pc;

    logic              ack;
    logic              pending_hold;
    logic [WORD-1:0]   target_aligned;

    assign ack            = req_q & imem_ack_i;
    // A request that is still out after this edge must keep its address.
    assign pending_hold   = req_q & ~imem_ack_i;
    assign target_aligned = branch_target_i & THUMB_BIT_MASK;

    fetch_skid_buffer #(
        .INST_W (INST_W)
    ) u_skid (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .load_i  (skid_load),
        .drain_i (skid_drain),
        .clear_i (skid_clear),
        .inst_i  (imem_rdata_i),
        .pc_i    (req_addr_q),
        .valid_o (skid_valid),
        .inst_o  (skid_inst),
        .pc_o    (skid_pc)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            req_q      <= 1'b0;
            inst_q     <= '0;
            out_pc_q   <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            req_q      <= req_d;
            inst_q     <= inst_d;
            out_pc_q   <= out_pc_d;
            valid_q    <= valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        req_d      = req_q;
        inst_d     = inst_q;
        out_pc_d   = out_pc_q;
        valid_d    = valid_q;
        skid_load  = 1'b0;
        skid_drain = 1'b0;
        skid_clear = 1'b0;

        if (take_branch_i) begin
            pc_d       = target_aligned;
            valid_d    = 1'b0;
            skid_clear = 1'b1;
            if (pending_hold) begin
                // old request still in flight; its address stays on the bus
                state_d = DRAIN;
            end else begin
                state_d    = FETCH;
                req_addr_d = target_aligned;
                req_d      = 1'b1;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = FETCH;
                    req_d   = flush_pipeline_i | ~stall_i;
                end
                DRAIN: begin
                    if (flush_pipeline_i) begin
                        valid_d    = 1'b0;
                        skid_clear = 1'b1;
                    end
                    if (ack) begin
                        state_d    = FETCH;
                        req_addr_d = pc_q;
                        req_d      = flush_pipeline_i | ~stall_i;
                    end
                end
                FETCH: begin
                    if (flush_pipeline_i) begin
                        // acked data (if any) is dropped; same address is refetched
                        valid_d    = 1'b0;
                        skid_clear = 1'b1;
                        req_d      = 1'b1;
                    end else if (stall_i) begin
                        // req_d defaults to req_q: an outstanding request stays,
                        // no new one starts
                        if (ack) begin
                            skid_load  = 1'b1;
                            pc_d       = req_addr_q + PC_INCREMENT;
                            req_addr_d = req_addr_q + PC_INCREMENT;
                            req_d      = 1'b0;
                        end
                    end else begin
                        req_d = 1'b1;
                        if (ack) begin
                            inst_d     = imem_rdata_i;
                            out_pc_d   = req_addr_q;
                            valid_d    = 1'b1;
                            pc_d       = req_addr_q + PC_INCREMENT;
                            req_addr_d = req_addr_q + PC_INCREMENT;
                        end else if (skid_valid) begin
                            inst_d     = skid_inst;
                            out_pc_d   = skid_pc;
                            valid_d    = 1'b1;
                            skid_drain = 1'b1;
                        end else begin
                            valid_d = 1'b0;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                end
            endcase
        end
    end

    assign imem_req_o        = req_q;
    assign imem_addr_o       = req_addr_q;
    assign instruction_o     = inst_q;
    assign program_counter_o = out_pc_q;
    assign is_valid_o        = valid_q;

`ifdef FETCH_REDIRECT_STATS_EN
    logic [31:0] redirect_cnt_q;
    logic [31:0] drained_cnt_q;
    logic        drain_ack;

    assign drain_ack = (state_q == DRAIN) & ack;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            redirect_cnt_q <= '0;
            drained_cnt_q  <= '0;
        end else begin
            if (take_branch_i) redirect_cnt_q <= sat_inc(redirect_cnt_q);
            if (drain_ack)     drained_cnt_q  <= sat_inc(drained_cnt_q);
        end
    end

    assign redirect_count_o = redirect_cnt_q;
    assign drained_count_o  = drained_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_redirect_unit.sv
module tb_fetch_redirect_unit;

    localparam int NCYC = 28;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        take_branch = 1'b0;
    logic        flush = 1'b0;
    logic        stall = 1'b0;
    logic [31:0] target = 32'h0;
    logic        imem_req;
    logic        imem_ack;
    logic [31:0] imem_addr;
    logic [15:0] imem_rdata;
    logic [15:0] instruction;
    logic [31:0] program_counter;
    logic        is_valid;
`ifdef FETCH_REDIRECT_STATS_EN
    logic [31:0] redirect_count;
    logic [31:0] drained_count;
`endif

    int checks = 0;
    int errors = 0;
    int ack_lat = 0;
    int req_age;
    bit mon_en = 1'b1;

    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_pc_q[$];

    // accepted memory transactions (req & ack), in order
    localparam logic [31:0] EXP_ADDR [20] = '{
        32'h0, 32'h2, 32'h4, 32'h6, 32'h8, 32'h100, 32'h102, 32'hC, 32'hE, 32'h10,
        32'h12, 32'h14, 32'hFFFF_FFFC, 32'hFFFF_FFFE, 32'h0, 32'h2, 32'h2, 32'h4,
        32'h0, 32'h2};
    // instructions decode accepts (valid, not stalled, not killed that cycle)
    localparam logic [31:0] EXP_PC [12] = '{
        32'h0, 32'h2, 32'h4, 32'h6, 32'hC, 32'hE, 32'h10, 32'hFFFF_FFFC,
        32'hFFFF_FFFE, 32'h2, 32'h4, 32'h0};

    int          lat_t   [NCYC];
    logic        stall_t [NCYC];
    logic        br_t    [NCYC];
    logic        fl_t    [NCYC];
    logic [31:0] tgt_t   [NCYC];

    fetch_redirect_unit #(
        .RESET_PC (32'h0000_0000),
        .INST_W   (16)
    ) dut (
        .clk_i             (clk),
        .reset_i           (rst),
        .take_branch_i     (take_branch),
        .flush_pipeline_i  (flush),
        .branch_target_i   (target),
        .stall_i           (stall),
        .imem_req_o        (imem_req),
        .imem_addr_o       (imem_addr),
        .imem_ack_i        (imem_ack),
        .imem_rdata_i      (imem_rdata),
        .instruction_o     (instruction),
        .program_counter_o (program_counter),
        .is_valid_o        (is_valid)
`ifdef FETCH_REDIRECT_STATS_EN
        ,
        .redirect_count_o  (redirect_count),
        .drained_count_o   (drained_count)
`endif
    );

    always #5 clk = ~clk;

    // memory: acks once a request has been up for ack_lat cycles
    always @(posedge clk or posedge rst) begin
        if (rst) req_age <= 0;
        else if (!imem_req || imem_ack) req_age <= 0;
        else req_age <= req_age + 1;
    end
    assign imem_ack   = imem_req && (req_age >= ack_lat);
    assign imem_rdata = imem_addr[15:0] ^ 16'hA5A5;

    function automatic logic [15:0] inst_of(input logic [31:0] a);
        return a[15:0] ^ 16'hA5A5;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic extra(input string name, input logic [31:0] act);
        checks++;
        errors++;
        $display("FAIL %s unexpected output %h (nothing expected)", name, act);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (!rst && mon_en) begin
            if (imem_req && imem_ack) begin
                if (exp_addr_q.size() == 0) extra("req_addr", imem_addr);
                else chk("req_addr", imem_addr, exp_addr_q.pop_front());
            end
            if (is_valid && !stall && !take_branch && !flush) begin
                if (exp_pc_q.size() == 0) extra("out_pc", program_counter);
                else begin
                    logic [31:0] epc;
                    epc = exp_pc_q.pop_front();
                    chk("out_pc", program_counter, epc);
                    chk("out_inst", {16'h0, instruction}, {16'h0, inst_of(epc)});
                end
            end
        end
    end

    task automatic apply(input int k);
        stall       = stall_t[k];
        take_branch = br_t[k];
        flush       = fl_t[k];
        target      = tgt_t[k];
        ack_lat     = lat_t[k];
    endtask

    initial begin
        for (int k = 0; k < NCYC; k++) begin
            lat_t[k] = 0; stall_t[k] = 1'b0; br_t[k] = 1'b0; fl_t[k] = 1'b0; tgt_t[k] = 32'h0;
        end
        lat_t[5] = 3; lat_t[6] = 3; lat_t[7] = 3;
        br_t[6] = 1'b1;  tgt_t[6]  = 32'h0000_0101;
        br_t[10] = 1'b1; tgt_t[10] = 32'h0000_000C;
        lat_t[13] = 2; lat_t[14] = 2; lat_t[15] = 2;
        stall_t[13] = 1'b1; stall_t[14] = 1'b1; stall_t[15] = 1'b1;
        br_t[18] = 1'b1; stall_t[18] = 1'b1; tgt_t[18] = 32'hFFFF_FFFD;
        fl_t[22] = 1'b1;
        lat_t[25] = 5; lat_t[26] = 5; lat_t[27] = 5;
        br_t[26] = 1'b1; tgt_t[26] = 32'h0000_0200;

        foreach (EXP_ADDR[i]) exp_addr_q.push_back(EXP_ADDR[i]);
        foreach (EXP_PC[i]) exp_pc_q.push_back(EXP_PC[i]);

        @(posedge clk); #1;
        chk("rst_req", {31'h0, imem_req}, 32'h0);
        chk("rst_valid", {31'h0, is_valid}, 32'h0);
        chk("rst_inst", {16'h0, instruction}, 32'h0);
        chk("rst_pc", program_counter, 32'h0);
        rst = 1'b0;
        apply(0);

        for (int k = 1; k < NCYC; k++) begin
            @(posedge clk); #1;
            apply(k);
            case (k)
                7: begin
                    chk("drain_req", {31'h0, imem_req}, 32'h1);
                    chk("drain_addr", imem_addr, 32'h8);
                    chk("drain_valid", {31'h0, is_valid}, 32'h0);
                end
                9:  chk("redir_addr", imem_addr, 32'h100);
                14: begin
                    chk("stall_hold_valid", {31'h0, is_valid}, 32'h1);
                    chk("stall_hold_pc", program_counter, 32'hE);
                    chk("stall_req_held", {31'h0, imem_req}, 32'h1);
                    chk("stall_req_addr", imem_addr, 32'h10);
                end
                16: begin
                    chk("skid_no_req", {31'h0, imem_req}, 32'h0);
                    chk("skid_out_pc", program_counter, 32'hE);
                end
                19: begin
                    chk("br_stall_valid", {31'h0, is_valid}, 32'h0);
                    chk("br_stall_req", {31'h0, imem_req}, 32'h1);
                    chk("br_stall_addr", imem_addr, 32'hFFFF_FFFC);
                end
                21: chk("wrap_addr", imem_addr, 32'h0);
                23: begin
                    chk("flush_valid", {31'h0, is_valid}, 32'h0);
                    chk("flush_pc_kept", imem_addr, 32'h2);
                end
                27: begin
`ifdef FETCH_REDIRECT_STATS_EN
                    chk("redirect_count", redirect_count, 32'd4);
                    chk("drained_count", drained_count, 32'd1);
`endif
                    chk("drain2_addr", imem_addr, 32'h6);
                end
                default: ;
            endcase
        end

        #1 rst = 1'b1;
        #1;
        chk("async_rst_req", {31'h0, imem_req}, 32'h0);
        chk("async_rst_valid", {31'h0, is_valid}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        ack_lat = 0;
        take_branch = 1'b0;
        chk("post_rst_idle_req", {31'h0, imem_req}, 32'h0);
`ifdef FETCH_REDIRECT_STATS_EN
        chk("post_rst_redirect_count", redirect_count, 32'd0);
        chk("post_rst_drained_count", drained_count, 32'd0);
`endif
        @(posedge clk); #1;
        chk("restart_req", {31'h0, imem_req}, 32'h1);
        chk("restart_addr", imem_addr, 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        mon_en = 1'b0;
        chk("addr_queue_left", exp_addr_q.size(), 32'd0);
        chk("pc_queue_left", exp_pc_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
